// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the frame-buffer loader: FSM state encoding, byte
// width, default raster geometry, default sync marker and the checksum
// accumulation helper.
// -----------------------------------------------------------------------------
package fb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } fb_state_t;

    localparam int               BYTE_BITS          = 8;
    localparam int               VGA_WIDTH_DEFAULT  = 640;
    localparam int               VGA_HEIGHT_DEFAULT = 480;
    localparam logic [BYTE_BITS-1:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Running frame checksum: XOR of every payload byte.
    function automatic logic [BYTE_BITS-1:0] csum_step(
        input logic [BYTE_BITS-1:0] acc,
        input logic [BYTE_BITS-1:0] data
    );
        return acc ^ data;
    endfunction

endpackage

// File: rtl/fb_bit_serializer.sv
// -----------------------------------------------------------------------------
// fb_bit_serializer
// Holds one byte and presents it MSB first, one bit per cycle, for exactly
// BYTE_BITS cycles after a load.
//   clk, rst   : clock, synchronous active-high reset
//   load       : capture load_data this cycle (bits appear from next cycle)
//   load_data  : byte to serialise
//   valid      : a bit is being presented this cycle
//   empty      : no bits pending (inverse of valid)
//   bit_out    : current bit (MSB of the shift register)
//   last       : current bit is the final one of the byte
// -----------------------------------------------------------------------------
module fb_bit_serializer
    import fb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [BYTE_BITS-1:0] load_data,
    output logic                 valid,
    output logic                 empty,
    output logic                 bit_out,
    output logic                 last
);

    localparam int CNT_W = $clog2(BYTE_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTE_BITS - 1);

    logic [BYTE_BITS-1:0] shift_r;
    logic [CNT_W-1:0]     cnt_r;
    logic                 active_r;

    // Shift register, bit counter and active flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r  <= '0;
            cnt_r    <= '0;
            active_r <= 1'b0;
        end else if (load) begin
            shift_r  <= load_data;
            cnt_r    <= '0;
            active_r <= 1'b1;
        end else if (active_r) begin
            shift_r  <= {shift_r[BYTE_BITS-2:0], 1'b0};
            cnt_r    <= cnt_r + CNT_W'(1);
            active_r <= (cnt_r != CNT_LAST);
        end
    end

    assign valid   = active_r;
    assign empty   = ~active_r;
    assign bit_out = shift_r[BYTE_BITS-1];
    assign last    = active_r & (cnt_r == CNT_LAST);

endmodule

// File: rtl/fb_loader.sv
// -----------------------------------------------------------------------------
// fb_loader
// Receives a sync-framed byte stream over valid/ready and writes each byte as
// 8 monochrome pixels (MSB first) into the write port of the frame buffer at
// linear pixel id y*VGA_WIDTH + x.
//   clk, rst     : clock, synchronous active-high reset
//   in_data      : payload byte          in_valid : byte valid
//   in_ready     : byte accepted this cycle when in_valid is also high
//   fb_we        : frame-buffer write enable
//   fb_addr      : pixel id being written
//   fb_data      : pixel value (1 = white)
//   busy         : frame load in progress
//   frame_done   : one-cycle pulse, frame written successfully
//   frame_error  : one-cycle pulse, frame aborted
// Optional build macro FB_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
// checked in a CHECK state.
// -----------------------------------------------------------------------------
module fb_loader
    import fb_pkg::*;
#(
    parameter int                   VGA_WIDTH      = VGA_WIDTH_DEFAULT,
    parameter int                   VGA_HEIGHT     = VGA_HEIGHT_DEFAULT,
    parameter int                   BUFFER_SIZE    = VGA_WIDTH * VGA_HEIGHT,
    parameter int                   ADDR_WIDTH     = 19,
    parameter logic [BYTE_BITS-1:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int unsigned          TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BYTE_BITS-1:0]  in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  fb_we,
    output logic [ADDR_WIDTH-1:0] fb_addr,
    output logic                  fb_data,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_error
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BUFFER_SIZE - 1);
    localparam int TMO_W = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST =
        (TIMEOUT_CYCLES == 32'd0) ? '0 : TMO_W'(TIMEOUT_CYCLES - 32'd1);
    localparam bit TMO_EN = (TIMEOUT_CYCLES != 32'd0);

    if ((BUFFER_SIZE % BYTE_BITS) != 0) begin : g_bad_size
        $error("fb_loader: BUFFER_SIZE must be a multiple of 8");
    end
    if ((64'd1 << ADDR_WIDTH) < 64'(BUFFER_SIZE)) begin : g_bad_addr
        $error("fb_loader: ADDR_WIDTH too small for BUFFER_SIZE");
    end

    fb_state_t             state_r, state_s;
    logic                  busy_r, frame_done_r, frame_error_r;
    logic                  done_s, err_s;
    logic                  in_ready_s, accept_s, idle_s, tmo_hit_s;
    logic                  start_s, issue_s, last_write_s, ser_load_s;
    logic                  ser_valid_s, ser_empty_s, ser_bit_s, ser_last_s;
    logic [ADDR_WIDTH-1:0] pix_cnt_r, addr_r;
    logic [TMO_W-1:0]      tmo_r;
`ifdef FB_LOADER_CHECKSUM_EN
    logic [BYTE_BITS-1:0]  csum_r;
`endif

    fb_bit_serializer u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (ser_load_s),
        .load_data (in_data),
        .valid     (ser_valid_s),
        .empty     (ser_empty_s),
        .bit_out   (ser_bit_s),
        .last      (ser_last_s)
    );

    assign accept_s     = in_valid & in_ready_s;
    assign start_s      = (state_r == IDLE) & accept_s & (in_data == SYNC_BYTE);
    assign ser_load_s   = (state_r == LOAD) & accept_s;
    // A write is due next cycle on a fresh load or while bits remain.
    assign issue_s      = ser_load_s | (ser_valid_s & ~ser_last_s);
    assign last_write_s = ser_valid_s & (addr_r == LAST_ADDR);
    assign tmo_hit_s    = TMO_EN & idle_s & (tmo_r == TMO_LAST);

    // Byte acceptance window per state.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            IDLE:    in_ready_s = 1'b1;
            LOAD:    in_ready_s = ser_empty_s;
            CHECK:   in_ready_s = 1'b1;
            default: in_ready_s = 1'b0;
        endcase
    end

    // Cycles that count toward the inter-byte timeout.
    always_comb begin
        idle_s = 1'b0;
        case (state_r)
            LOAD:    idle_s = ser_empty_s & ~accept_s;
`ifdef FB_LOADER_CHECKSUM_EN
            CHECK:   idle_s = ~accept_s;
`endif
            default: idle_s = 1'b0;
        endcase
    end

    // Next-state and completion pulses.
    always_comb begin
        state_s = state_r;
        done_s  = 1'b0;
        err_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_s = LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                if (tmo_hit_s) begin
                    state_s = IDLE;
                    err_s   = 1'b1;
                end else if (last_write_s) begin
`ifdef FB_LOADER_CHECKSUM_EN
                    state_s = CHECK;
`else
                    state_s = IDLE;
                    done_s  = 1'b1;
`endif
                end else begin
                    state_s = LOAD;
                end
            end
`ifdef FB_LOADER_CHECKSUM_EN
            CHECK: begin
                if (accept_s) begin
                    state_s = IDLE;
                    if (in_data == csum_r) begin
                        done_s = 1'b1;
                    end else begin
                        err_s  = 1'b1;
                    end
                end else if (tmo_hit_s) begin
                    state_s = IDLE;
                    err_s   = 1'b1;
                end else begin
                    state_s = CHECK;
                end
            end
`endif
            default: state_s = IDLE;
        endcase
    end

    // State register and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            busy_r        <= 1'b0;
            frame_done_r  <= 1'b0;
            frame_error_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            busy_r        <= (state_s != IDLE);
            frame_done_r  <= done_s;
            frame_error_r <= err_s;
        end
    end

    // Pixel counter and write address; the counter saturates on the last pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt_r <= '0;
            addr_r    <= '0;
        end else if (start_s) begin
            pix_cnt_r <= '0;
        end else if (issue_s) begin
            addr_r <= pix_cnt_r;
            if (pix_cnt_r != LAST_ADDR) begin
                pix_cnt_r <= pix_cnt_r + ADDR_WIDTH'(1);
            end
        end
    end

    // Inter-byte timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_r <= '0;
        end else if (accept_s || tmo_hit_s) begin
            tmo_r <= '0;
        end else if (idle_s) begin
            tmo_r <= tmo_r + TMO_W'(1);
        end
    end

`ifdef FB_LOADER_CHECKSUM_EN
    // Running XOR of the payload bytes of the current frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            csum_r <= '0;
        end else if (start_s) begin
            csum_r <= '0;
        end else if (ser_load_s) begin
            csum_r <= csum_step(csum_r, in_data);
        end
    end
`endif

    assign in_ready    = in_ready_s;
    assign fb_we       = ser_valid_s;
    assign fb_data     = ser_bit_s;
    assign fb_addr     = addr_r;
    assign busy        = busy_r;
    assign frame_done  = frame_done_r;
    assign frame_error = frame_error_r;

endmodule

// File: tb/tb_fb_loader.sv
// -----------------------------------------------------------------------------
// tb_fb_loader
// Directed bench for fb_loader on a 8x8 (64-pixel) frame with a 20-cycle
// timeout. A transaction-level model predicts every output each cycle; literal
// expectations pin the model on the key scenarios.
// -----------------------------------------------------------------------------
module tb_fb_loader;

    localparam int BUF = 64;
    localparam int AW  = 6;
    localparam int TMO = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready, fb_we, fb_data, busy, frame_done, frame_error;
    logic [AW-1:0] fb_addr;

    fb_loader #(
        .VGA_WIDTH(8), .VGA_HEIGHT(8), .ADDR_WIDTH(AW),
        .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
        .busy(busy), .frame_done(frame_done), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model: mode 0 idle, 1 loading, 2 awaiting checksum. Pending pixel writes
    // are queued when a byte is accepted and drained one per cycle.
    typedef struct packed { logic [AW-1:0] a; logic d; } wr_t;
    wr_t           wq[$];
    int            m_mode = 0, m_idle = 0, m_pix = 0;
    logic [7:0]    m_x = 8'h00;
    logic          exp_we = 1'b0, exp_data = 1'b0, exp_done = 1'b0, exp_err = 1'b0;
    logic          exp_busy = 1'b0, exp_rdy = 1'b1;
    logic [AW-1:0] exp_addr = '0;

    int   wr_addr[$];
    logic wr_data[$];
    int   done_cnt = 0, err_cnt = 0, rdy_low = 0, max_addr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic rdy, acc, cur_last;
        wr_t  w;
        rdy      = (m_mode == 0) || (m_mode == 1 && wq.size() == 0 && !exp_we) || (m_mode == 2);
        acc      = in_valid && rdy;
        cur_last = exp_we && (int'(exp_addr) == BUF - 1);
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (rst) begin
            m_mode = 0; m_idle = 0; m_pix = 0; m_x = 8'h00;
            wq.delete();
            exp_we = 1'b0; exp_addr = '0; exp_data = 1'b0;
        end else begin
            if (m_mode == 0) begin
                if (acc && in_data == 8'hA5) begin
                    m_mode = 1; m_pix = 0; m_idle = 0; m_x = 8'h00;
                end
            end else if (m_mode == 1) begin
                if (cur_last) begin
`ifdef FB_LOADER_CHECKSUM_EN
                    m_mode = 2;
`else
                    m_mode = 0; exp_done = 1'b1;
`endif
                end else if (acc) begin
                    for (int i = 0; i < 8; i++) begin
                        w.a = AW'(m_pix + i);
                        w.d = in_data[7-i];
                        wq.push_back(w);
                    end
                    m_pix += 8; m_x ^= in_data; m_idle = 0;
                end else if (wq.size() == 0 && !exp_we) begin
                    m_idle++;
                    if (m_idle == TMO) begin m_mode = 0; exp_err = 1'b1; m_idle = 0; end
                end
            end else begin
                if (acc) begin
                    if (in_data == m_x) exp_done = 1'b1;
                    else                exp_err  = 1'b1;
                    m_mode = 0;
                end else begin
                    m_idle++;
                    if (m_idle == TMO) begin m_mode = 0; exp_err = 1'b1; m_idle = 0; end
                end
            end
            if (wq.size() > 0) begin
                w = wq.pop_front();
                exp_we = 1'b1; exp_addr = w.a; exp_data = w.d;
            end else begin
                exp_we = 1'b0;
            end
        end
        exp_busy = (m_mode != 0);
        exp_rdy  = (m_mode == 0) || (m_mode == 1 && wq.size() == 0 && !exp_we) || (m_mode == 2);
    endtask

    // Per-cycle compare against the model, activity log, then model advance.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("fb_we", fb_we, exp_we);
                chk("fb_addr", fb_addr, exp_addr);
                if (exp_we) chk("fb_data", fb_data, exp_data);
                chk("busy", busy, exp_busy);
                chk("frame_done", frame_done, exp_done);
                chk("frame_error", frame_error, exp_err);
                chk("in_ready", in_ready, exp_rdy);
                if (fb_we) begin
                    wr_addr.push_back(int'(fb_addr));
                    wr_data.push_back(fb_data);
                    if (int'(fb_addr) > max_addr) max_addr = int'(fb_addr);
                end
                if (frame_done)  done_cnt++;
                if (frame_error) err_cnt++;
                if (!in_ready)   rdy_low++;
            end
            model_step();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr.delete(); wr_data.delete();
        done_cnt = 0; err_cnt = 0; rdy_low = 0; max_addr = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_byte: byte %0h not accepted within 100 cycles", b);
        end
    endtask

    initial begin
        logic [7:0] pat;
        int         ones;

        repeat (3) tick();
        rst    = 1'b0;
        chk_en = 1'b1;
        chk("reset_fb_we", fb_we, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_fb_addr", fb_addr, 0);

        // Non-sync byte ignored, sync starts the frame.
        clear_log();
        send_byte(8'h00);
        chk("junk_ignored_busy", busy, 1'b0);
        send_byte(8'hA5);
        chk("busy_after_sync", busy, 1'b1);
        chk("no_writes_before_payload", wr_addr.size(), 0);

        // First payload byte 0xB4: 8 writes, MSB first, ready low 8 cycles.
        clear_log();
        send_byte(8'hB4);
        repeat (10) tick();
        pat = 8'hB4;
        chk("b4_write_count", wr_addr.size(), 8);
        chk("b4_ready_low", rdy_low, 8);
        for (int i = 0; i < 8 && i < wr_addr.size(); i++) begin
            chk("b4_addr", wr_addr[i], i);
            chk("b4_bit", wr_data[i], pat[7-i]);
        end
        for (int i = 0; i < 7; i++) send_byte(8'hFF);
`ifdef FB_LOADER_CHECKSUM_EN
        send_byte(8'h4B);
`endif
        repeat (12) tick();
        chk("frame1_writes", wr_addr.size(), 64);
        chk("frame1_done", done_cnt, 1);
        chk("frame1_error", err_cnt, 0);

        // Full frame of 0xFF.
        clear_log();
        send_byte(8'hA5);
        for (int i = 0; i < 8; i++) send_byte(8'hFF);
`ifdef FB_LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        repeat (12) tick();
        ones = 0;
        foreach (wr_data[i]) if (wr_data[i] == 1'b1) ones++;
        chk("ff_writes", wr_addr.size(), 64);
        chk("ff_ones", ones, 64);
        chk("ff_max_addr", max_addr, 63);
        chk("ff_done", done_cnt, 1);
        chk("ff_idle_busy", busy, 1'b0);

        // Timeout after two bytes (second one equals the sync value).
        clear_log();
        send_byte(8'hA5);
        send_byte(8'h3C);
        send_byte(8'hA5);
        repeat (40) tick();
        chk("tmo_error", err_cnt, 1);
        chk("tmo_no_done", done_cnt, 0);
        chk("tmo_writes", wr_addr.size(), 16);
        chk("tmo_addr_held", fb_addr, 15);
        chk("tmo_busy", busy, 1'b0);
        clear_log();
        send_byte(8'hA5);
        send_byte(8'h81);
        repeat (3) tick();
        chk("restart_addr0", (wr_addr.size() > 0) ? wr_addr[0] : 99, 0);
        repeat (35) tick();

        // Reset during the 4th bit of a byte.
        clear_log();
        send_byte(8'hA5);
        send_byte(8'hF0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("rst_fb_we", fb_we, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_fb_addr", fb_addr, 0);
        chk("rst_writes_before", wr_addr.size(), 4);
        rst = 1'b0;
        tick();

`ifdef FB_LOADER_CHECKSUM_EN
        // Checksum good (0x08) then bad (0x09).
        clear_log();
        send_byte(8'hA5);
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        send_byte(8'h08);
        repeat (3) tick();
        chk("csum_good_done", done_cnt, 1);
        chk("csum_good_err", err_cnt, 0);
        clear_log();
        send_byte(8'hA5);
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        send_byte(8'h09);
        repeat (3) tick();
        chk("csum_bad_done", done_cnt, 0);
        chk("csum_bad_err", err_cnt, 1);
`endif

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
